tcp_malloc_arbiter: RTL and testbench



---
 rtl/tcp_malloc_arbiter_pkg.sv | 18 +
 rtl/tcp_malloc_arbiter_if.sv | 69 ++++++
 rtl/fifo_1r1w.sv | 65 ++++++
 rtl/tcp_malloc_arbiter_rr.sv | 36 +++
 rtl/tcp_malloc_arbiter.sv | 130 +++++++++++++
 tb/tb_tcp_malloc_arbiter.sv | 292 +++++++++++++++++++++++++++++
 6 files changed

// File: rtl/tcp_malloc_arbiter_pkg.sv
// Shared defaults and helpers for the tcp_malloc requester arbiter.
// The requester ID type and the modulo-N pointer step are used by the arbiter and its bench.
package tcp_malloc_pkg;

    localparam int NUM_REQ_DEF    = 4;
    localparam int PTR_W_DEF      = 16;
    localparam int LEN_MAX_DEF    = 2048;
    localparam int LOG2_OUTST_DEF = 2;
    localparam int REQ_W_DEF      = $clog2(NUM_REQ_DEF);

    typedef logic [REQ_W_DEF-1:0] req_id_t;

    // Step a round-robin index, wrapping at n even when n is not a power of two.
    function automatic int rr_next(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/tcp_malloc_arbiter_if.sv
// Bundle of requester-side and tcp_malloc-side handshake signals around the arbiter.
// slave = the arbiter's view, master = the surrounding engines plus tcp_malloc.
interface tcp_malloc_arbiter_if
    import tcp_malloc_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int PTR_W   = PTR_W_DEF,
    parameter int LEN_W   = $clog2(LEN_MAX_DEF)
);

    logic [NUM_REQ-1:0]       req_malloc_val;
    logic [NUM_REQ*LEN_W-1:0] req_malloc_len;
    logic [NUM_REQ-1:0]       req_malloc_rdy;

    logic [NUM_REQ-1:0]       req_resp_val;
    logic                     req_resp_success;
    logic [PTR_W-1:0]         req_resp_addr;
    logic [NUM_REQ-1:0]       req_resp_rdy;

    logic [NUM_REQ-1:0]       req_free_val;
    logic [NUM_REQ*PTR_W-1:0] req_free_addr;
    logic [NUM_REQ*LEN_W-1:0] req_free_len;
    logic [NUM_REQ-1:0]       req_free_rdy;

    logic                     malloc_req_val;
    logic [LEN_W-1:0]         malloc_req_len;
    logic                     malloc_req_rdy;

    logic                     malloc_resp_val;
    logic                     malloc_resp_success;
    logic [PTR_W-1:0]         malloc_resp_addr;
    logic                     malloc_resp_rdy;

    logic                     free_req_val;
    logic [PTR_W-1:0]         free_req_addr;
    logic [LEN_W-1:0]         free_req_len;
    logic                     free_req_rdy;

    modport slave (
        input  req_malloc_val, req_malloc_len,
        output req_malloc_rdy,
        output req_resp_val, req_resp_success, req_resp_addr,
        input  req_resp_rdy,
        input  req_free_val, req_free_addr, req_free_len,
        output req_free_rdy,
        output malloc_req_val, malloc_req_len,
        input  malloc_req_rdy,
        input  malloc_resp_val, malloc_resp_success, malloc_resp_addr,
        output malloc_resp_rdy,
        output free_req_val, free_req_addr, free_req_len,
        input  free_req_rdy
    );

    modport master (
        output req_malloc_val, req_malloc_len,
        input  req_malloc_rdy,
        input  req_resp_val, req_resp_success, req_resp_addr,
        output req_resp_rdy,
        output req_free_val, req_free_addr, req_free_len,
        input  req_free_rdy,
        input  malloc_req_val, malloc_req_len,
        output malloc_req_rdy,
        output malloc_resp_val, malloc_resp_success, malloc_resp_addr,
        input  malloc_resp_rdy,
        input  free_req_val, free_req_addr, free_req_len,
        output free_req_rdy
    );

endinterface

// File: rtl/fifo_1r1w.sv
// Small one-read one-write FIFO with occupancy count; push is refused while full
// (even if a pop happens the same cycle) and pop is ignored while empty.
module fifo_1r1w #(
    parameter int width_p    = 2,
    parameter int log2_els_p = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [width_p-1:0]    data_i,
    input  logic                  pop_i,
    output logic [width_p-1:0]    data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [log2_els_p:0]   count_o
);

    localparam int ELS = 1 << log2_els_p;

    logic [width_p-1:0]    mem_q [ELS];
    logic [log2_els_p-1:0] wr_q, wr_d;
    logic [log2_els_p-1:0] rd_q, rd_d;
    logic [log2_els_p:0]   cnt_q, cnt_d;
    logic                  do_push_s;
    logic                  do_pop_s;

    assign full_o  = (cnt_q == (log2_els_p+1)'(ELS));
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    // Pointer and occupancy next-state.
    always_comb begin
        do_push_s = push_i && !full_o;
        do_pop_s  = pop_i && !empty_o;
        wr_d      = do_push_s ? wr_q + log2_els_p'(1) : wr_q;
        rd_d      = do_pop_s  ? rd_q + log2_els_p'(1) : rd_q;
        case ({do_push_s, do_pop_s})
            2'b10:   cnt_d = cnt_q + (log2_els_p+1)'(1);
            2'b01:   cnt_d = cnt_q - (log2_els_p+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage; contents are don't-care until written so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_q] <= data_i;
        end
    end

endmodule

// File: rtl/tcp_malloc_arbiter_rr.sv
// Combinational round-robin picker: first requester at or above ptr_i, wrapping modulo N.
// Produces both a one-hot grant and its index; N need not be a power of two.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             gnt_val_o
);

    int   raw_s;
    int   idx_s;
    logic hit_s;

    // Scan once around the ring starting at the pointer; the first hit wins.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        gnt_val_o = 1'b0;
        raw_s     = 0;
        idx_s     = 0;
        hit_s     = 1'b0;
        for (int off = 0; off < N; off++) begin
            raw_s     = int'(ptr_i) + off;
            idx_s     = (raw_s >= N) ? raw_s - N : raw_s;
            hit_s     = !gnt_val_o && req_i[idx_s];
            gnt_o[idx_s] = gnt_o[idx_s] | hit_s;
            gnt_idx_o = hit_s ? IDX_W'(idx_s) : gnt_idx_o;
            gnt_val_o = gnt_val_o | hit_s;
        end
    end

endmodule

// File: rtl/tcp_malloc_arbiter.sv
// Shares one tcp_malloc among NUM_REQ requesters: independent round-robin on malloc and
// free, and an in-order tag FIFO that steers each malloc response back to its issuer.
module tcp_malloc_arbiter
    import tcp_malloc_pkg::*;
#(
    parameter int NUM_REQ       = NUM_REQ_DEF,
    parameter int PTR_W         = PTR_W_DEF,
    parameter int LEN_MAX       = LEN_MAX_DEF,
    parameter int LEN_W         = $clog2(LEN_MAX),
    parameter int REQ_W         = $clog2(NUM_REQ),
    parameter int LOG2_OUTST    = LOG2_OUTST_DEF,
    parameter bit REPORT_ORPHAN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    tcp_malloc_arbiter_if.slave   bus,
    output logic [LOG2_OUTST:0]   outstanding_cnt_o,
    output logic                  err_orphan_resp_o
);

    logic [REQ_W-1:0]    rr_malloc_ptr_q, rr_malloc_ptr_d;
    logic [REQ_W-1:0]    rr_free_ptr_q, rr_free_ptr_d;
    logic                err_q, err_d;

    logic [NUM_REQ-1:0]  m_gnt_s, f_gnt_s;
    logic [REQ_W-1:0]    m_idx_s, f_idx_s;
    logic                m_any_s, f_any_s;

    logic                tag_full_s, tag_empty_s;
    logic [REQ_W-1:0]    tag_head_s;
    logic [NUM_REQ-1:0]  head_oh_s;
    logic [LOG2_OUTST:0] tag_cnt_s;

    logic                m_hs_s, r_hs_s, f_hs_s, orphan_s;
    logic [LEN_W-1:0]    m_len_s, f_len_s;
    logic [PTR_W-1:0]    f_addr_s;

    rr_arbiter #(.N(NUM_REQ), .IDX_W(REQ_W)) u_malloc_arb (
        .req_i     (bus.req_malloc_val),
        .ptr_i     (rr_malloc_ptr_q),
        .gnt_o     (m_gnt_s),
        .gnt_idx_o (m_idx_s),
        .gnt_val_o (m_any_s)
    );

    rr_arbiter #(.N(NUM_REQ), .IDX_W(REQ_W)) u_free_arb (
        .req_i     (bus.req_free_val),
        .ptr_i     (rr_free_ptr_q),
        .gnt_o     (f_gnt_s),
        .gnt_idx_o (f_idx_s),
        .gnt_val_o (f_any_s)
    );

    fifo_1r1w #(.width_p(REQ_W), .log2_els_p(LOG2_OUTST)) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (m_hs_s),
        .data_i  (m_idx_s),
        .pop_i   (r_hs_s),
        .data_o  (tag_head_s),
        .full_o  (tag_full_s),
        .empty_o (tag_empty_s),
        .count_o (tag_cnt_s)
    );

    // One-hot AND-OR mux of the winning requesters' payloads.
    always_comb begin
        m_len_s  = '0;
        f_len_s  = '0;
        f_addr_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            m_len_s  = m_len_s  | (bus.req_malloc_len[i*LEN_W +: LEN_W] & {LEN_W{m_gnt_s[i]}});
            f_len_s  = f_len_s  | (bus.req_free_len[i*LEN_W +: LEN_W]   & {LEN_W{f_gnt_s[i]}});
            f_addr_s = f_addr_s | (bus.req_free_addr[i*PTR_W +: PTR_W]  & {PTR_W{f_gnt_s[i]}});
        end
    end

    // A full tag FIFO holds off new mallocs so every response has an owner.
    assign bus.malloc_req_val = m_any_s && !tag_full_s;
    assign bus.malloc_req_len = m_len_s;
    assign bus.req_malloc_rdy = m_gnt_s & {NUM_REQ{bus.malloc_req_rdy && !tag_full_s}};
    assign m_hs_s             = bus.malloc_req_val && bus.malloc_req_rdy;

    assign head_oh_s            = NUM_REQ'(1) << tag_head_s;
    assign bus.req_resp_val     = head_oh_s & {NUM_REQ{bus.malloc_resp_val && !tag_empty_s}};
    assign bus.req_resp_success = bus.malloc_resp_success;
    assign bus.req_resp_addr    = bus.malloc_resp_addr;
    assign bus.malloc_resp_rdy  = !tag_empty_s && |(bus.req_resp_rdy & head_oh_s);
    assign r_hs_s               = bus.malloc_resp_val && bus.malloc_resp_rdy;
    assign orphan_s             = bus.malloc_resp_val && tag_empty_s;

    assign bus.free_req_val  = f_any_s;
    assign bus.free_req_addr = f_addr_s;
    assign bus.free_req_len  = f_len_s;
    assign bus.req_free_rdy  = f_gnt_s & {NUM_REQ{bus.free_req_rdy}};
    assign f_hs_s            = bus.free_req_val && bus.free_req_rdy;

    // Pointers advance past the winner only on a handshake; the orphan flag is sticky.
    always_comb begin
        rr_malloc_ptr_d = m_hs_s ? REQ_W'(rr_next(int'(m_idx_s), NUM_REQ)) : rr_malloc_ptr_q;
        rr_free_ptr_d   = f_hs_s ? REQ_W'(rr_next(int'(f_idx_s), NUM_REQ)) : rr_free_ptr_q;
        err_d           = err_q | orphan_s;
    end

    // Arbiter state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_malloc_ptr_q <= '0;
            rr_free_ptr_q   <= '0;
            err_q           <= 1'b0;
        end else begin
            rr_malloc_ptr_q <= rr_malloc_ptr_d;
            rr_free_ptr_q   <= rr_free_ptr_d;
            err_q           <= err_d;
        end
    end

    assign outstanding_cnt_o = tag_cnt_s;
    assign err_orphan_resp_o = err_q;

`ifndef SYNTHESIS
    // Report a response arriving while no requester is waiting for one.
    always_ff @(posedge clk) begin
        if (REPORT_ORPHAN && !rst && orphan_s) begin
            $error("tcp_malloc_arbiter: malloc response with empty tag FIFO");
        end
    end
`endif

endmodule

// File: tb/tb_tcp_malloc_arbiter.sv
// Scoreboard bench: a behavioural tcp_malloc returns sequential slices; each grant pushes the
// expected requester/success/address, popped and compared when the response is delivered.
module tb_tcp_malloc_arbiter;
    import tcp_malloc_pkg::*;

    localparam int N     = 4;
    localparam int PW    = 16;
    localparam int LMAX  = 2048;
    localparam int LW    = $clog2(LMAX);
    localparam int LO    = 2;
    localparam int DEPTH = 1 << LO;

    typedef struct { int id; bit succ; int addr; } exp_t;
    typedef struct { bit succ; int addr; } pend_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [LO:0]   cnt;
    logic          err;

    always #5 clk = ~clk;

    tcp_malloc_arbiter_if #(.NUM_REQ(N), .PTR_W(PW), .LEN_W(LW)) bus ();

    tcp_malloc_arbiter #(
        .NUM_REQ(N), .PTR_W(PW), .LEN_MAX(LMAX), .LOG2_OUTST(LO), .REPORT_ORPHAN(1'b0)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .bus               (bus.slave),
        .outstanding_cnt_o (cnt),
        .err_orphan_resp_o (err)
    );

    int    n_cmp = 0;
    int    n_err = 0;
    exp_t  sb_q[$];
    pend_t tcp_q[$];
    int    m_log[$];
    int    f_log[$];
    int    m_ptr, f_ptr, occ, next_addr, fail_id, sz;
    bit    err_exp, tcp_rdy, resp_en, m_drop, orphan_inj;
    int    t1_exp[5] = '{0, 1, 2, 3, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic int oh2idx(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) begin
            if (v[i]) r = (r == -1) ? i : -2;
        end
        return r;
    endfunction

    function automatic logic [LW-1:0] m_len(input int i);
        return LW'(64 * (i + 1));
    endfunction

    function automatic logic [PW-1:0] f_addr(input int i);
        return PW'(32'h4000 + i * 256);
    endfunction

    function automatic logic [LW-1:0] f_len(input int i);
        return LW'(32 * (i + 1));
    endfunction

    // One clock: drive tcp_malloc side, check all combinational outputs, track handshakes.
    task automatic tick();
        int g, fw, hid, gi, mdrop, fdrop;
        bit resp_drv, orph, succ;
        logic [N-1:0] exp_rdy, exp_rv, exp_frdy;
        exp_t e;
        mdrop = -1;
        fdrop = -1;
        resp_drv = orphan_inj || (resp_en && tcp_q.size() > 0);
        bus.malloc_req_rdy      = tcp_rdy;
        bus.malloc_resp_val     = resp_drv;
        bus.malloc_resp_success = (tcp_q.size() > 0) ? tcp_q[0].succ : 1'b1;
        bus.malloc_resp_addr    = (tcp_q.size() > 0) ? PW'(tcp_q[0].addr) : 16'hdead;
        #1;
        chk("cnt", 32'(cnt), occ);
        chk("err", 32'(err), 32'(err_exp));

        g = rr_pick(bus.req_malloc_val, m_ptr);
        chk("mreq_val", 32'(bus.malloc_req_val), 32'(g >= 0 && occ < DEPTH));
        exp_rdy = (g >= 0 && occ < DEPTH && tcp_rdy) ? (N'(1) << g) : '0;
        chk("mreq_rdy", 32'(bus.req_malloc_rdy), 32'(exp_rdy));
        if (g >= 0) chk("mreq_len", 32'(bus.malloc_req_len), 32'(m_len(g)));

        hid = (sb_q.size() > 0) ? sb_q[0].id : -1;
        exp_rv = (resp_drv && hid >= 0) ? (N'(1) << hid) : '0;
        chk("resp_val", 32'(bus.req_resp_val), 32'(exp_rv));
        chk("resp_rdy", 32'(bus.malloc_resp_rdy), 32'((hid >= 0) ? bus.req_resp_rdy[hid] : 1'b0));
        orph = bus.malloc_resp_val && (occ == 0);

        fw = rr_pick(bus.req_free_val, f_ptr);
        chk("free_val", 32'(bus.free_req_val), 32'(fw >= 0));
        exp_frdy = (fw >= 0 && bus.free_req_rdy) ? (N'(1) << fw) : '0;
        chk("free_rdy", 32'(bus.req_free_rdy), 32'(exp_frdy));
        if (fw >= 0) begin
            chk("free_addr", 32'(bus.free_req_addr), 32'(f_addr(fw)));
            chk("free_len", 32'(bus.free_req_len), 32'(f_len(fw)));
        end

        if (bus.malloc_resp_val && bus.malloc_resp_rdy) begin
            if (sb_q.size() == 0) begin
                chk("resp_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("resp_id", oh2idx(bus.req_resp_val), e.id);
                chk("resp_succ", 32'(bus.req_resp_success), 32'(e.succ));
                chk("resp_addr", 32'(bus.req_resp_addr), e.addr);
            end
            if (tcp_q.size() > 0) void'(tcp_q.pop_front());
            occ--;
        end
        if (bus.malloc_req_val && bus.malloc_req_rdy) begin
            gi = oh2idx(bus.req_malloc_rdy);
            chk("mgnt", gi, g);
            m_log.push_back(gi);
            if (g >= 0) begin
                succ = (g != fail_id);
                tcp_q.push_back('{succ, succ ? next_addr : 0});
                sb_q.push_back('{g, succ, succ ? next_addr : 0});
                if (succ) next_addr += LMAX;
                m_ptr = (g + 1) % N;
                if (m_drop) mdrop = g;
            end
            occ++;
        end
        if (bus.free_req_val && bus.free_req_rdy && fw >= 0) begin
            f_log.push_back(oh2idx(bus.req_free_rdy));
            f_ptr = (fw + 1) % N;
            fdrop = fw;
        end
        @(posedge clk);
        err_exp = err_exp | orph;
        @(negedge clk);
        if (mdrop >= 0) bus.req_malloc_val[mdrop] = 1'b0;
        if (fdrop >= 0) bus.req_free_val[fdrop] = 1'b0;
    endtask

    task automatic drain();
        resp_en = 1'b1;
        bus.req_resp_rdy = '1;
        for (int k = 0; k < 40 && sb_q.size() > 0; k++) tick();
        chk("drain", sb_q.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_malloc_val  = '0;
        bus.req_free_val    = '0;
        bus.malloc_resp_val = 1'b0;
        orphan_inj = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_ptr = 0; f_ptr = 0; occ = 0; err_exp = 1'b0;
        sb_q.delete(); tcp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            bus.req_malloc_len[i*LW +: LW] = m_len(i);
            bus.req_free_addr[i*PW +: PW]  = f_addr(i);
            bus.req_free_len[i*LW +: LW]   = f_len(i);
        end
        bus.req_resp_rdy        = '1;
        bus.free_req_rdy        = 1'b1;
        bus.malloc_req_rdy      = 1'b1;
        bus.malloc_resp_success = 1'b1;
        bus.malloc_resp_addr    = '0;
        tcp_rdy = 1'b1; resp_en = 1'b1; m_drop = 1'b0; fail_id = -1; next_addr = 0;
        do_reset();

        #1;
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_resp_val", 32'(bus.req_resp_val), 32'd0);
        chk("rst_resp_rdy", 32'(bus.malloc_resp_rdy), 32'd0);
        @(negedge clk);

        // All four request continuously; responses one cycle after each grant.
        bus.req_malloc_val = 4'hF;
        m_log.delete();
        repeat (5) tick();
        bus.req_malloc_val = '0;
        drain();
        chk("t1_ngrant", m_log.size(), 5);
        for (int i = 0; i < 5 && i < m_log.size(); i++) chk("t1_order", m_log[i], t1_exp[i]);

        // Tag FIFO fills with no responses; one response frees exactly one slot.
        resp_en = 1'b0;
        bus.req_malloc_val = 4'hF;
        repeat (6) tick();
        chk("t2_full_cnt", 32'(cnt), 32'd4);
        chk("t2_full_rdy", 32'(bus.req_malloc_rdy), 32'd0);
        resp_en = 1'b1;
        tick();
        resp_en = 1'b0;
        chk("t2_cnt3", 32'(cnt), 32'd3);
        sz = m_log.size();
        tick();
        chk("t2_resume", m_log.size(), sz + 1);
        bus.req_malloc_val = '0;
        drain();

        // Head-of-line: requester 2 stalls, requester 3's response must wait.
        m_drop = 1'b1;
        resp_en = 1'b0;
        bus.req_malloc_val = 4'b0100;
        tick();
        bus.req_malloc_val[3] = 1'b1;
        tick();
        resp_en = 1'b1;
        bus.req_resp_rdy = 4'b1011;
        repeat (3) tick();
        chk("t3_hol_cnt", 32'(cnt), 32'd2);
        chk("t3_hol_rv3", 32'(bus.req_resp_val[3]), 32'd0);
        chk("t3_hol_rdy", 32'(bus.malloc_resp_rdy), 32'd0);
        drain();

        // Failed allocation for requester 1 still pops its tag.
        fail_id = 1;
        bus.req_malloc_val = 4'b0010;
        tick();
        chk("t4_cnt1", 32'(cnt), 32'd1);
        tick();
        chk("t4_cnt0", 32'(cnt), 32'd0);
        fail_id = -1;

        // Concurrent malloc and frees; free ring must wrap 3 -> 0.
        f_log.delete();
        sz = m_log.size();
        bus.req_free_val   = 4'b1001;
        bus.req_malloc_val = 4'b0010;
        tick();
        chk("t5_malloc", m_log.size(), sz + 1);
        chk("t5_nfree1", f_log.size(), 1);
        tick();
        chk("t5_nfree2", f_log.size(), 2);
        bus.req_free_val = 4'b0110;
        tick();
        chk("t5_nfree3", f_log.size(), 3);
        if (f_log.size() == 3) begin
            chk("t5_free0", f_log[0], 0);
            chk("t5_free3", f_log[1], 3);
            chk("t5_wrap", f_log[2], 1);
        end
        bus.req_free_val = '0;
        drain();

        // Orphan response sets a sticky flag that only reset clears.
        orphan_inj = 1'b1;
        tick();
        orphan_inj = 1'b0;
        chk("t6_err", 32'(err), 32'd1);
        repeat (3) tick();
        chk("t6_sticky", 32'(err), 32'd1);
        do_reset();
        #1;
        chk("t6_clr", 32'(err), 32'd0);
        chk("t6_cnt", 32'(cnt), 32'd0);
        @(negedge clk);
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
